// File: rtl/cpu_mem_loader_pkg.sv
// rtl/cpu_mem_loader_pkg.sv - op encodings and FSM state type for cpu_mem_loader
package cpu_mem_loader_pkg;

  localparam logic [1:0] OP_LOAD_IMEM = 2'd0;
  localparam logic [1:0] OP_LOAD_DMEM = 2'd1;
  localparam logic [1:0] OP_RUN       = 2'd2;
  localparam logic [1:0] OP_DUMP_DMEM = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_HOLD = 3'd5
  } state_e;

endpackage

// File: rtl/cpu_mem_loader.sv
// rtl/cpu_mem_loader.sv - host-side loader/runner/dumper for the cpu external memory ports
module cpu_mem_loader
  import cpu_mem_loader_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4,
  parameter int OP_W      = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [31:0]      cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [31:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [31:0]      wdata_ext_2,
  input  logic [31:0]      rdata_ext_2,
  output logic             enable,
  output logic             busy,
  output logic             done
);

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [31:0]      addr_q, addr_d;

  logic [31:0]      addr_ext_q, addr_ext_d;
  logic             wen_ext_q, wen_ext_d;
  logic [31:0]      wdata_ext_q, wdata_ext_d;
  logic [31:0]      addr_ext2_q, addr_ext2_d;
  logic             wen_ext2_q, wen_ext2_d;
  logic             ren_ext2_q, ren_ext2_d;
  logic [31:0]      wdata_ext2_q, wdata_ext2_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             enable_q, enable_d;
  logic             done_q, done_d;

  logic             last_idx;
  logic [31:0]      addr_next;

  // Handshake readiness is a pure function of the state so the host sees it without a cycle of lag.
  assign cmd_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);

  assign ren_ext     = 1'b0;
  assign addr_ext    = addr_ext_q;
  assign wen_ext     = wen_ext_q;
  assign wdata_ext   = wdata_ext_q;
  assign addr_ext_2  = addr_ext2_q;
  assign wen_ext_2   = wen_ext2_q;
  assign ren_ext_2   = ren_ext2_q;
  assign wdata_ext_2 = wdata_ext2_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign enable      = enable_q;
  assign done        = done_q;

  // idx_q is the 0-based word (or cycle) index; the command finishes when it reaches len-1.
  assign last_idx  = (idx_q == (len_q - LEN_W'(1)));
  assign addr_next = addr_q + STEP;

  // Next-state and registered-output computation for the single command FSM.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    len_d        = len_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    addr_ext_d   = addr_ext_q;
    wdata_ext_d  = wdata_ext_q;
    addr_ext2_d  = addr_ext2_q;
    wdata_ext2_d = wdata_ext2_q;
    wen_ext_d    = 1'b0;
    wen_ext2_d   = 1'b0;
    ren_ext2_d   = 1'b0;
    enable_d     = 1'b0;
    done_d       = 1'b0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          len_d  = cmd_len;
          addr_d = cmd_base;
          idx_d  = '0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (cmd_op == OP_W'(OP_RUN)) begin
            // enable rises the cycle after acceptance, so the first run cycle is issued here.
            enable_d = 1'b1;
            state_d  = ST_RUN;
          end else if (cmd_op == OP_W'(OP_DUMP_DMEM)) begin
            ren_ext2_d  = 1'b1;
            addr_ext2_d = cmd_base;
            state_d     = ST_RD_REQ;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          if (op_q == OP_W'(OP_LOAD_IMEM)) begin
            wen_ext_d   = 1'b1;
            addr_ext_d  = addr_q;
            wdata_ext_d = in_data;
          end else begin
            wen_ext2_d   = 1'b1;
            addr_ext2_d  = addr_q;
            wdata_ext2_d = in_data;
          end
          addr_d = addr_next;
          idx_d  = idx_q + LEN_W'(1);
          if (last_idx) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        if (last_idx) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          enable_d = 1'b1;
          idx_d    = idx_q + LEN_W'(1);
        end
      end

      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        out_data_d  = rdata_ext_2;
        out_valid_d = 1'b1;
        state_d     = ST_RD_HOLD;
      end

      ST_RD_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_idx) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d       = idx_q + LEN_W'(1);
            addr_d      = addr_next;
            addr_ext2_d = addr_next;
            ren_ext2_d  = 1'b1;
            state_d     = ST_RD_REQ;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and all registered port outputs; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      addr_ext_q   <= '0;
      wen_ext_q    <= 1'b0;
      wdata_ext_q  <= '0;
      addr_ext2_q  <= '0;
      wen_ext2_q   <= 1'b0;
      ren_ext2_q   <= 1'b0;
      wdata_ext2_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      enable_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      addr_ext_q   <= addr_ext_d;
      wen_ext_q    <= wen_ext_d;
      wdata_ext_q  <= wdata_ext_d;
      addr_ext2_q  <= addr_ext2_d;
      wen_ext2_q   <= wen_ext2_d;
      ren_ext2_q   <= ren_ext2_d;
      wdata_ext2_q <= wdata_ext2_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      enable_q     <= enable_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb/tb_cpu_mem_loader.sv - self-checking bench for cpu_mem_loader
module tb_cpu_mem_loader;
  import cpu_mem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_base;
  logic [15:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [31:0] wdata_ext_2;
  logic [31:0] rdata_ext_2;
  logic        enable;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  cpu_mem_loader #(.LEN_W(16), .ADDR_STEP(4), .OP_W(2)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .enable(enable), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference model: expected write streams, expected dump stream, and the data memory image.
  logic [63:0] imem_q[$];
  logic [63:0] dmem_q[$];
  logic [31:0] dump_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sim_mem [logic [31:0]];

  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  // Stand-in data memory: writes land at the edge, reads return one cycle after ren.
  always @(posedge clk) begin
    if (wen_ext_2) sim_mem[addr_ext_2] = wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= sim_mem.exists(addr_ext_2) ? sim_mem[addr_ext_2] : fill(addr_ext_2);
  end

  // Per-cycle compare process.
  logic        mon_on = 1'b0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic        done_prev = 1'b0;
  int n_en = 0, n_ren2 = 0, n_done = 0;

  always begin
    @(negedge clk);
    #2;
    if (mon_on) begin
      check("ren_ext_tied_low", ren_ext, 0);
      check("wen2_ren2_exclusive", wen_ext_2 & ren_ext_2, 0);
      check("enable_vs_port_enables", enable & (wen_ext | wen_ext_2 | ren_ext_2), 0);
      check("cmd_ready_vs_busy", cmd_ready, !busy);
      if (wen_ext) begin
        check("imem_write_expected", imem_q.size() != 0, 1);
        if (imem_q.size() != 0) begin
          logic [63:0] e;
          e = imem_q.pop_front();
          check("imem_write_addr", addr_ext, e[63:32]);
          check("imem_write_data", wdata_ext, e[31:0]);
        end
      end
      if (wen_ext_2) begin
        check("dmem_write_expected", dmem_q.size() != 0, 1);
        if (dmem_q.size() != 0) begin
          logic [63:0] e;
          e = dmem_q.pop_front();
          check("dmem_write_addr", addr_ext_2, e[63:32]);
          check("dmem_write_data", wdata_ext_2, e[31:0]);
        end
      end
      if (ren_ext_2) n_ren2++;
      if (enable) n_en++;
      if (done) begin
        n_done++;
        check("done_single_cycle", done_prev, 0);
      end
      if (hold_prev) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_out_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        check("dump_word_expected", dump_q.size() != 0, 1);
        if (dump_q.size() != 0) check("dump_word", out_data, dump_q.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      done_prev = done;
    end
  end

  // Driver state and helpers.
  logic [31:0] wq[$];
  logic        vpat[$];
  int          gap_pct = 0;
  int          rdy_pct = 100;
  logic [31:0] last_addr, last_data, first_held;

  task automatic settle();
    @(negedge clk);
    #3;
    check("imem_queue_drained", imem_q.size(), 0);
    check("dmem_queue_drained", dmem_q.size(), 0);
    check("dump_queue_drained", dump_q.size(), 0);
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [31:0] base, input logic [15:0] len);
    int budget;
    budget = 0;
    @(negedge clk);
    cmd_op = op; cmd_base = base; cmd_len = len; cmd_valid = 1'b1;
    while (!cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("cmd_accept", cmd_ready, 1);
    if (op == OP_DUMP_DMEM)
      for (int i = 0; i < int'(len); i++) dump_q.push_back(ref_rd(base + 32'(i) * 32'd4));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [1:0] op, input logic [31:0] base, input int nbeats, output int got);
    int cyc;
    logic v;
    logic [31:0] d, a;
    got = 0;
    cyc = 0;
    while (got < nbeats && cyc < 500) begin
      if (vpat.size() != 0) v = vpat.pop_front();
      else v = ($urandom_range(0, 99) >= gap_pct);
      if (v) d = (wq.size() != 0) ? wq.pop_front() : $urandom;
      else d = $urandom;
      in_valid = v;
      in_data = d;
      if (v && in_ready) begin
        a = base + 32'(got) * 32'd4;
        if (op == OP_LOAD_IMEM) imem_q.push_back({a, d});
        else begin
          dmem_q.push_back({a, d});
          ref_mem[a] = d;
        end
        got++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] op, input logic [31:0] base, input logic [15:0] len);
    int got;
    issue_cmd(op, base, len);
    feed(op, base, int'(len), got);
    check("load_beats", got, len);
    check("load_done_pulse", done, 1);
    check("load_in_ready_dropped", in_ready, 0);
    check("load_idle_after", busy, 0);
    if (len != 0) begin
      if (op == OP_LOAD_IMEM) begin
        check("last_write_imem_en", wen_ext, 1);
        last_addr = addr_ext; last_data = wdata_ext;
      end else begin
        check("last_write_dmem_en", wen_ext_2, 1);
        last_addr = addr_ext_2; last_data = wdata_ext_2;
      end
    end else begin
      check("len0_no_write", wen_ext | wen_ext_2, 0);
    end
    settle();
  endtask

  task automatic do_run(input logic [15:0] len);
    int e0;
    e0 = n_en;
    issue_cmd(OP_RUN, $urandom, len);
    for (int k = 0; k < int'(len); k++) begin
      check("run_enable_high", enable, 1);
      check("run_no_early_done", done, 0);
      check("run_cmd_ready_low", cmd_ready, 0);
      @(negedge clk);
    end
    check("run_enable_fell", enable, 0);
    check("run_done_pulse", done, 1);
    check("run_idle_at_done", busy, 0);
    settle();
    check("run_enable_cycles", n_en - e0, len);
  endtask

  task automatic do_dump(input logic [31:0] base, input logic [15:0] len, input int hold0);
    int got, cyc, r0;
    r0 = n_ren2;
    got = 0;
    cyc = 0;
    issue_cmd(OP_DUMP_DMEM, base, len);
    while (got < int'(len) && cyc < 2000) begin
      if (hold0 > 0 && got == 0 && out_valid) begin
        out_ready = 1'b0;
        first_held = out_data;
        hold0--;
      end else begin
        out_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      if (out_valid && out_ready) got++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("dump_words", got, len);
    check("dump_done_pulse", done, 1);
    check("dump_idle_after", busy, 0);
    check("dump_out_valid_dropped", out_valid, 0);
    settle();
    check("dump_ren_pulses", n_ren2 - r0, len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_base = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_enable", enable, 0);
    check("rst_wen_ext", wen_ext, 0);
    check("rst_addr_ext", addr_ext, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ren_ext_2", ren_ext_2, 0);
    arst_n = 1'b1;
    mon_on = 1'b1;

    // Program load, back-to-back beats.
    wq = '{32'h2008_0005, 32'h2009_0007, 32'h0109_5020};
    do_load(OP_LOAD_IMEM, 32'h0, 16'd3);
    check("imem_last_addr_literal", last_addr, 32'h0000_0008);
    check("imem_last_data_literal", last_data, 32'h0109_5020);

    // Data load with gapped in_valid.
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    wq = '{32'h1111_2222, 32'h3333_4444};
    do_load(OP_LOAD_DMEM, 32'h10, 16'd2);
    check("dmem_last_addr_literal", last_addr, 32'h0000_0014);
    check("dmem_last_data_literal", last_data, 32'h3333_4444);

    do_run(16'd20);

    do_dump(32'h10, 16'd2, 5);
    check("dump_held_word_literal", first_held, 32'h1111_2222);

    // Zero-length commands on every op.
    do_load(OP_LOAD_IMEM, 32'h40, 16'd0);
    do_load(OP_LOAD_DMEM, 32'h40, 16'd0);
    do_run(16'd0);
    do_dump(32'h40, 16'd0, 0);

    // Address wrap.
    wq = '{32'hCAFE_0001, 32'hCAFE_0002};
    do_load(OP_LOAD_IMEM, 32'hFFFF_FFFC, 16'd2);
    check("wrap_last_addr_literal", last_addr, 32'h0000_0000);

    // Reset in the middle of a 4-beat load after beat 1.
    issue_cmd(OP_LOAD_IMEM, 32'h200, 16'd4);
    gap_pct = 0;
    feed(OP_LOAD_IMEM, 32'h200, 2, got);
    check("pre_reset_beats", got, 2);
    arst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_wen_ext", wen_ext, 0);
    check("mid_rst_wen_ext_2", wen_ext_2, 0);
    check("mid_rst_ren_ext_2", ren_ext_2, 0);
    check("mid_rst_enable", enable, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_done", done, 0);
    arst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    settle();

    // Normal operation after reset.
    do_load(OP_LOAD_DMEM, 32'h80, 16'd3);
    do_dump(32'h80, 16'd3, 0);

    // Randomized command mix.
    gap_pct = 30;
    rdy_pct = 60;
    for (int n = 0; n < 30; n++) begin
      logic [1:0]  op;
      logic [31:0] base;
      logic [15:0] len;
      op = 2'($urandom_range(0, 3));
      base = 32'h100 + 32'd4 * 32'($urandom_range(0, 12));
      len = (op == OP_RUN) ? 16'($urandom_range(0, 12)) : 16'($urandom_range(0, 6));
      case (op)
        OP_RUN:       do_run(len);
        OP_DUMP_DMEM: do_dump(base, len, 0);
        default:      do_load(op, base, len);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_loader.md
Name: cpu_mem_loader

Overview:
Host-side initiator for the cpu external memory ports. The cpu only responds on these ports. This block drives them from a command interface and a word stream.
- Loads program words into instruction memory (addr_ext/wen_ext/wdata_ext) and data words into data memory (addr_ext_2/wen_ext_2/wdata_ext_2).
- Runs the core by holding enable for a counted number of cycles.
- Dumps data memory back out through ren_ext_2/rdata_ext_2 onto an output stream.
- Sits between the testbench/host and the cpu top.

Parameters:
- LEN_W, 16, width of cmd_len (word count or cycle count).
- ADDR_STEP, 4, address increment per word on the ext ports (byte addressing).
- OP_W, 2, width of cmd_op.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  OP_W  0=LOAD_IMEM, 1=LOAD_DMEM, 2=RUN, 3=DUMP_DMEM
- cmd_base  in  32  start byte address (ignored for RUN)
- cmd_len  in  LEN_W  words to transfer, or cycles to run
- in_valid  in  1  load word valid
- in_ready  out  1  load word accepted
- in_data  in  32  load word
- out_valid  out  1  dump word valid
- out_ready  in  1  dump word consumed
- out_data  out  32  dump word
- addr_ext  out  32  imem ext address
- wen_ext  out  1  imem ext write enable
- ren_ext  out  1  imem ext read enable (tied 0)
- wdata_ext  out  32  imem ext write data
- addr_ext_2  out  32  dmem ext address
- wen_ext_2  out  1  dmem ext write enable
- ren_ext_2  out  1  dmem ext read enable
- wdata_ext_2  out  32  dmem ext write data
- rdata_ext_2  in  32  dmem ext read data, valid 1 cycle after ren_ext_2
- enable  out  1  cpu run enable
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse on command completion

Behaviour:
- Reset (arst_n=0 at a clk edge) forces:
  - state=IDLE;
  - every output 0 except cmd_ready=1;
  - counters and address registers 0.
  - Reset mid-command abandons the command immediately; no further ext-port writes occur.
- All ext-port outputs, enable, out_valid, out_data and done are registered.
- States: IDLE, LOAD, RUN, RD_REQ, RD_WAIT, RD_HOLD.
- IDLE: cmd_ready=1. On cmd_valid, latch op, base and len, then:
  - len=0: stay IDLE; done=1 next cycle; no port activity.
  - LOAD_IMEM or LOAD_DMEM: go to LOAD.
  - RUN: go to RUN.
  - DUMP_DMEM: go to RD_REQ.
- cmd_ready is 0 in every state other than IDLE.
- LOAD:
  - in_ready=1 (combinational from state).
  - Each in_valid&in_ready beat i (0-based): next cycle, wen_ext (IMEM op) or wen_ext_2 (DMEM op) =1 for exactly one cycle, with address = base + i*ADDR_STEP and wdata = in_data.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
  - Idle beats produce no write.
  - After beat len-1 is accepted: in_ready drops in the same cycle the last write is issued, state returns to IDLE, and done pulses concurrently with that last write.
- RUN:
  - enable=1 for exactly len consecutive cycles, starting the cycle after acceptance.
  - All write enables and read enables are 0 throughout.
  - done pulses in the cycle after enable falls; state is IDLE in that cycle.
- DUMP:
  - RD_REQ: ren_ext_2=1 with addr_ext_2 = base + i*ADDR_STEP for one cycle, then go to RD_WAIT.
  - RD_WAIT: capture rdata_ext_2 into out_data; out_valid=1; go to RD_HOLD.
  - RD_HOLD: hold out_valid and out_data stable until out_ready. On the handshake:
    - if i<len-1: i++ and go to RD_REQ;
    - else: go to IDLE with a done pulse.
  - Throughput is at most 1 word per 3 cycles. Backpressure is unlimited and no word is lost.
- The block never drives wen_ext_2 and ren_ext_2 high in the same cycle. enable is never high while any write or read enable is high.
- Commands presented while busy stay pending; cmd_valid must be held by the source.

Decomposition:
- Package cpu_mem_loader_pkg holds the op encodings (OP_LOAD_IMEM=2'd0, OP_LOAD_DMEM=2'd1, OP_RUN=2'd2, OP_DUMP_DMEM=2'd3) and the state enum.
- No sub-module: one FSM, one LEN_W-bit index counter and one 32-bit address register, all in this block.

Test Plan:
- Reset 3 cycles, then LOAD_IMEM base=0x0 len=3 with in_data 0x20080005, 0x20090007, 0x01095020 -> wen_ext pulses with addr 0x0, 0x4, 0x8 and matching wdata; done pulses once; no wen_ext_2 activity.
- LOAD_DMEM base=0x10 len=2 with in_valid gapped (1,0,0,1) -> exactly two writes, at 0x10=first word and 0x14=second word; no write on the idle cycles.
- RUN len=20 -> enable high exactly 20 cycles; done pulses on cycle 21; cmd_ready is 0 for the whole run.
- DUMP_DMEM base=0x10 len=2 after the load above, with out_ready held low 5 cycles on word 0 -> out_data stays stable at the first word while held; then outputs the second word; exactly 2 ren_ext_2 pulses.
- Edge cases:
  - len=0 on each op -> done pulse only, no port activity.
  - base=0xFFFFFFFC len=2 load -> writes at 0xFFFFFFFC then 0x00000000.
- arst_n low mid-LOAD after beat 1 of 4 -> next cycle all enables are 0, cmd_ready=1, no further writes; a new command executes normally.
